sphere_hit_scanner: RTL and testbench

Shot-resolution block that sits opposite the 4-entry sphere register file. On a Fire request it sweeps `Read_index` 0..3, consumes the registered `Sphere_pos`/`curr_index` returns, and tests each sphere against the aim point. It selects the nearest sphere in range and drives `Hit`/`Hit_index` so the register file respawns that sphere on its next frame tick. It also keeps hit, miss and drop statistics for the HUD.

---
 rtl/sphere_hit_scanner_if.sv | 32 +++
 rtl/sphere_hit_scanner.sv | 159 +++++++++++++++
 tb/tb_sphere_hit_scanner.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sphere_hit_scanner_if.sv
// Sphere scanner bus: register file read port, shot request and HUD stats.
// The scanner is the slave; the register file / game side is the master.
interface sphere_hit_scanner_if;
  logic              Frame_Clk;
  logic              Fire;
  logic [63:0]       Aim_x;
  logic [63:0]       Aim_z;
  logic [2:0][63:0]  Sphere_pos;
  logic [1:0]        curr_index;
  logic [3:0]        dropped;
  logic [1:0]        Read_index;
  logic              Hit;
  logic [1:0]        Hit_index;
  logic              Busy;
  logic [15:0]       Score;
  logic [15:0]       Misses;
  logic [15:0]       Drops;

  modport slave (
    input  Frame_Clk, Fire, Aim_x, Aim_z,
    input  Sphere_pos, curr_index, dropped,
    output Read_index, Hit, Hit_index, Busy,
    output Score, Misses, Drops
  );

  modport master (
    output Frame_Clk, Fire, Aim_x, Aim_z,
    output Sphere_pos, curr_index, dropped,
    input  Read_index, Hit, Hit_index, Busy,
    input  Score, Misses, Drops
  );
endinterface

// File: rtl/sphere_hit_scanner.sv
// Shot resolver: sweeps the 4 spheres on Fire, picks the nearest one in
// range and asks the register file to respawn it on the next frame tick.
module sphere_hit_scanner #(
  parameter logic [63:0] RADIUS = 64'h000000F0_00000000
) (
  input  logic                Clk,
  input  logic                Reset,
  sphere_hit_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, ARMED} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [63:0] aim_x, aim_x_n;
  logic [63:0] aim_z, aim_z_n;
  logic        cand_vld, cand_vld_n;
  logic [1:0]  cand_idx, cand_idx_n;
  logic [63:0] cand_dep, cand_dep_n;
  logic        fc_old, fe;
  logic        hit, hit_n;
  logic [1:0]  hit_idx, hit_idx_n;
  logic        busy;
  logic [15:0] score, score_n;
  logic [15:0] misses, misses_n;
  logic [15:0] drops, drops_n;

  logic [64:0] dx, dz, adx, adz;
  logic        in_rng, eval, take;
  logic        c_vld;
  logic [1:0]  c_idx;
  logic [63:0] c_dep;
  logic [2:0]  pc;
  logic [16:0] dsum;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // fc_old resets high so a Frame_Clk held high through reset is no tick
  assign fe = ~fc_old & bus.Frame_Clk;

  assign dx = {bus.Sphere_pos[0][63], bus.Sphere_pos[0]}
            - {aim_x[63], aim_x};
  assign dz = {bus.Sphere_pos[2][63], bus.Sphere_pos[2]}
            - {aim_z[63], aim_z};
  assign adx = dx[64] ? -dx : dx;
  assign adz = dz[64] ? -dz : dz;
  assign in_rng = (adx < {1'b0, RADIUS})
               && (adz < {1'b0, RADIUS});

  // Returns are valid from the second SCAN cycle through DRAIN
  assign eval = (state == SCAN && cnt != 2'd0)
             || (state == DRAIN);
  assign take = eval && in_rng
             && (!cand_vld
             || $signed(bus.Sphere_pos[1]) < $signed(cand_dep));

  assign c_vld = cand_vld | take;
  assign c_idx = take ? bus.curr_index : cand_idx;
  assign c_dep = take ? bus.Sphere_pos[1] : cand_dep;

  assign pc = {2'b0, bus.dropped[0]} + {2'b0, bus.dropped[1]}
            + {2'b0, bus.dropped[2]} + {2'b0, bus.dropped[3]};
  assign dsum = {1'b0, drops} + {14'b0, pc};
  assign drops_n = dsum[16] ? 16'hFFFF : dsum[15:0];

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    aim_x_n    = aim_x;
    aim_z_n    = aim_z;
    cand_vld_n = cand_vld;
    cand_idx_n = cand_idx;
    cand_dep_n = cand_dep;
    hit_n      = hit;
    hit_idx_n  = hit_idx;
    score_n    = score;
    misses_n   = misses;
    unique case (state)
      IDLE: if (bus.Fire) begin
        state_n    = SCAN;
        cnt_n      = 2'd0;
        aim_x_n    = bus.Aim_x;
        aim_z_n    = bus.Aim_z;
        cand_vld_n = 1'b0;
      end
      SCAN: if (fe) begin
        cnt_n      = 2'd0;
        cand_vld_n = 1'b0;
      end else begin
        cand_vld_n = c_vld;
        cand_idx_n = c_idx;
        cand_dep_n = c_dep;
        cnt_n      = cnt + 2'd1;
        if (cnt == 2'd3) state_n = DRAIN;
      end
      DRAIN: if (fe) begin
        state_n    = SCAN;
        cnt_n      = 2'd0;
        cand_vld_n = 1'b0;
      end else if (c_vld) begin
        state_n    = ARMED;
        hit_n      = 1'b1;
        hit_idx_n  = c_idx;
      end else begin
        state_n    = IDLE;
        misses_n   = sat_inc(misses);
      end
      ARMED: if (fe) begin
        state_n    = IDLE;
        hit_n      = 1'b0;
        score_n    = sat_inc(score);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      aim_x    <= 64'd0;
      aim_z    <= 64'd0;
      cand_vld <= 1'b0;
      cand_idx <= 2'd0;
      cand_dep <= 64'd0;
      fc_old   <= 1'b1;
      hit      <= 1'b0;
      hit_idx  <= 2'd0;
      busy     <= 1'b0;
      score    <= 16'd0;
      misses   <= 16'd0;
      drops    <= 16'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      aim_x    <= aim_x_n;
      aim_z    <= aim_z_n;
      cand_vld <= cand_vld_n;
      cand_idx <= cand_idx_n;
      cand_dep <= cand_dep_n;
      fc_old   <= bus.Frame_Clk;
      hit      <= hit_n;
      hit_idx  <= hit_idx_n;
      busy     <= (state_n != IDLE);
      score    <= score_n;
      misses   <= misses_n;
      drops    <= drops_n;
    end
  end

  assign bus.Read_index = (state == SCAN) ? cnt : 2'd0;
  assign bus.Hit        = hit;
  assign bus.Hit_index  = hit_idx;
  assign bus.Busy       = busy;
  assign bus.Score      = score;
  assign bus.Misses     = misses;
  assign bus.Drops      = drops;
endmodule

// File: tb/tb_sphere_hit_scanner.sv
// Bench for sphere_hit_scanner: registered register-file model, directed
// shots, and a scoreboard that resolves each shot when Busy drops.
module tb_sphere_hit_scanner;
  logic Clk = 1'b0;
  logic Reset;

  sphere_hit_scanner_if bus ();

  sphere_hit_scanner dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          hit;
    logic [1:0]  idx;
    logic [15:0] score;
    logic [15:0] misses;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [15:0] m_score = 16'd0;
  logic [15:0] m_miss  = 16'd0;

  logic [63:0] sx [4];
  logic [63:0] sd [4];
  logic [63:0] sz [4];

  function automatic logic [63:0] fx(input int ip,
                                     input logic [31:0] fr = 32'h0);
    return {ip, fr};
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_sph(input int i, input logic [63:0] x,
                         input logic [63:0] d, input logic [63:0] z);
    sx[i] = x;
    sd[i] = d;
    sz[i] = z;
  endtask

  task automatic all_far();
    for (int i = 0; i < 4; i++)
      set_sph(i, fx(10000), fx(100), fx(10000));
  endtask

  // Registered register-file read port
  always @(posedge Clk) begin
    bus.Sphere_pos <= {sz[bus.Read_index], sd[bus.Read_index],
                       sx[bus.Read_index]};
    bus.curr_index <= bus.Read_index;
  end

  // Scoreboard monitor: a shot resolves when Busy falls
  bit         busy_q = 1'b0;
  bit         saw_hit = 1'b0;
  logic [1:0] seen_idx = 2'd0;

  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      busy_q  = 1'b0;
      saw_hit = 1'b0;
    end else begin
      if (bus.Hit) begin
        saw_hit  = 1'b1;
        seen_idx = bus.Hit_index;
      end
      if (busy_q && !bus.Busy) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_hit", 64'(saw_hit), 64'(e.hit));
          if (e.hit) check("sb_hit_index", 64'(seen_idx), 64'(e.idx));
          check("sb_score", 64'(bus.Score), 64'(e.score));
          check("sb_misses", 64'(bus.Misses), 64'(e.misses));
        end
        saw_hit = 1'b0;
      end
      busy_q = bus.Busy;
    end
  end

  // One complete shot; optional Fire pulse with another aim while busy
  task automatic shot(input logic [63:0] ax, input logic [63:0] az,
                      input bit exp_hit, input logic [1:0] exp_idx,
                      input bit bf = 1'b0,
                      input logic [63:0] bx = 64'd0,
                      input logic [63:0] bz = 64'd0);
    exp_t e;
    bus.Aim_x = ax;
    bus.Aim_z = az;
    bus.Fire  = 1'b1;
    if (exp_hit) m_score++;
    else m_miss++;
    e = '{exp_hit, exp_idx, m_score, m_miss};
    sb.push_back(e);
    @(negedge Clk);
    bus.Fire = 1'b0;
    check("busy_t1", 64'(bus.Busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("read_index", 64'(bus.Read_index), 64'(k));
      if (bf && k == 1) begin
        bus.Fire  = 1'b1;
        bus.Aim_x = bx;
        bus.Aim_z = bz;
      end else if (bf && k == 2) begin
        bus.Fire = 1'b0;
      end
      @(negedge Clk);
    end
    check("hit_in_drain", 64'(bus.Hit), 64'd0);
    @(negedge Clk);
    if (exp_hit) begin
      check("hit_t6", 64'(bus.Hit), 64'd1);
      check("hit_index_t6", 64'(bus.Hit_index), 64'(exp_idx));
      repeat (2) begin
        @(negedge Clk);
        check("hit_held", 64'(bus.Hit), 64'd1);
      end
      bus.Frame_Clk = 1'b1;
      check("hit_fe_cycle", 64'(bus.Hit), 64'd1);
      @(negedge Clk);
      bus.Frame_Clk = 1'b0;
      check("hit_clear", 64'(bus.Hit), 64'd0);
      check("score_after", 64'(bus.Score), 64'(m_score));
      check("busy_after", 64'(bus.Busy), 64'd0);
    end else begin
      check("miss_no_hit", 64'(bus.Hit), 64'd0);
      check("misses_t6", 64'(bus.Misses), 64'(m_miss));
      check("miss_busy", 64'(bus.Busy), 64'd0);
      check("miss_score_kept", 64'(bus.Score), 64'(m_score));
    end
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit_seen;
    all_far();
    Reset          = 1'b1;
    bus.Frame_Clk  = 1'b1;
    bus.Fire       = 1'b0;
    bus.Aim_x      = 64'd0;
    bus.Aim_z      = 64'd0;
    bus.dropped    = 4'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Frame_Clk high out of reset must not look like a tick
    hit_seen = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.Hit) hit_seen = 1'b1;
    end
    check("rst_hit_never", 64'(hit_seen), 64'd0);
    check("rst_read_index", 64'(bus.Read_index), 64'd0);
    check("rst_hit_index", 64'(bus.Hit_index), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_score", 64'(bus.Score), 64'd0);
    check("rst_misses", 64'(bus.Misses), 64'd0);
    check("rst_drops", 64'(bus.Drops), 64'd0);
    bus.Frame_Clk = 1'b0;
    @(negedge Clk);

    // Single hit on sphere 2
    all_far();
    set_sph(2, fx(100), fx(4000), fx(-500));
    shot(fx(100, 32'h8000_0000), fx(-480), 1'b1, 2'd2);

    // Nearest wins, lower index nearer
    all_far();
    set_sph(0, fx(0), fx(2840), fx(0));
    set_sph(1, fx(10), fx(3800), fx(10));
    shot(fx(5), fx(5), 1'b1, 2'd0);

    // Nearest wins, higher index nearer
    all_far();
    set_sph(1, fx(10), fx(3800), fx(10));
    set_sph(3, fx(0), fx(1000), fx(0));
    shot(fx(5), fx(5), 1'b1, 2'd3);

    // Equal depth keeps the lower index
    all_far();
    set_sph(1, fx(0), fx(3000), fx(0));
    set_sph(3, fx(1), fx(3000), fx(-1));
    shot(fx(0), fx(0), 1'b1, 2'd1);

    // Exact radius on x, then on z: both miss
    all_far();
    set_sph(0, fx(0), fx(100), fx(0));
    shot(fx(240), fx(0), 1'b0, 2'd0);
    shot(fx(0), fx(-240), 1'b0, 2'd0);
    // Just inside the radius hits
    shot(fx(239, 32'hFFFF_FFFF), fx(0), 1'b1, 2'd0);

    // Frame tick at Read_index 2 restarts with updated sphere 3
    begin
      exp_t e;
      all_far();
      bus.Aim_x = fx(0);
      bus.Aim_z = fx(0);
      bus.Fire  = 1'b1;
      m_score++;
      e = '{1'b1, 2'd3, m_score, m_miss};
      sb.push_back(e);
      @(negedge Clk);
      bus.Fire = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("restart_pre_ri", 64'(bus.Read_index), 64'd2);
      bus.Frame_Clk = 1'b1;
      set_sph(3, fx(0), fx(500), fx(0));
      @(negedge Clk);
      bus.Frame_Clk = 1'b0;
      check("restart_busy", 64'(bus.Busy), 64'd1);
      for (int k = 0; k < 4; k++) begin
        check("restart_ri", 64'(bus.Read_index), 64'(k));
        @(negedge Clk);
      end
      check("restart_drain_hit", 64'(bus.Hit), 64'd0);
      @(negedge Clk);
      check("restart_hit", 64'(bus.Hit), 64'd1);
      check("restart_hit_index", 64'(bus.Hit_index), 64'd3);
      @(negedge Clk);
      bus.Frame_Clk = 1'b1;
      @(negedge Clk);
      bus.Frame_Clk = 1'b0;
      check("restart_hit_clear", 64'(bus.Hit), 64'd0);
      check("restart_score", 64'(bus.Score), 64'(m_score));
      @(negedge Clk);
    end

    // Drops: popcount of one pulse
    bus.dropped = 4'b1011;
    @(negedge Clk);
    bus.dropped = 4'b0000;
    check("drops_1011", 64'(bus.Drops), 64'd3);

    // Fire while busy is ignored; original aim decides
    all_far();
    set_sph(0, fx(0), fx(100), fx(0));
    set_sph(1, fx(5000), fx(100), fx(5000));
    shot(fx(0), fx(0), 1'b1, 2'd0, 1'b1, fx(5000), fx(5000));
    repeat (3) begin
      check("no_second_scan", 64'(bus.Busy), 64'd0);
      @(negedge Clk);
    end

    // Drops saturate at FFFF
    bus.dropped = 4'b1111;
    repeat (16382) @(negedge Clk);
    check("drops_near_sat", 64'(bus.Drops), 64'hFFFB);
    repeat (10) @(negedge Clk);
    check("drops_sat", 64'(bus.Drops), 64'hFFFF);
    bus.dropped = 4'b0000;
    @(negedge Clk);
    check("drops_sat_hold", 64'(bus.Drops), 64'hFFFF);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
